// File: rtl/pci_master_if.sv
// pci_master_if: local request/word-stream signals plus PCI initiator pins (FRAME#, IRDY#, C/BE#, AD, DEVSEL#, TRDY#); master = initiator view, slave = local logic/target view
interface pci_master_if;
  logic        Req;
  logic [3:0]  ReqCmd;
  logic [31:0] ReqAddr;
  logic [3:0]  ReqLen;
  logic [31:0] WrData;
  logic [3:0]  WrBE;
  logic        WrPop;
  logic [31:0] RdData;
  logic        RdValid;
  logic        Busy;
  logic        Done;
  logic        Abort;
  logic        Frame;
  logic        Irdy;
  logic [3:0]  CBE;
  logic        CBEOe;
  logic [31:0] ADOut;
  logic        ADOe;
  logic [31:0] ADIn;
  logic        Devsel;
  logic        Trdy;
  modport master (
    input  Req, ReqCmd, ReqAddr, ReqLen, WrData, WrBE, ADIn, Devsel, Trdy,
    output WrPop, RdData, RdValid, Busy, Done, Abort, Frame, Irdy, CBE, CBEOe, ADOut, ADOe
  );
  modport slave (
    output Req, ReqCmd, ReqAddr, ReqLen, WrData, WrBE, ADIn, Devsel, Trdy,
    input  WrPop, RdData, RdValid, Busy, Done, Abort, Frame, Irdy, CBE, CBEOe, ADOut, ADOe
  );
endinterface

// File: rtl/pci_master.sv
// pci_master: PCI burst initiator (ports: Clock, RST async active-low, bus = pci_master_if.master carrying request, write/read word streams and PCI pins); PCI_MASTER_TIMEOUT_EN adds DEVSEL# master abort
module pci_master #(
  parameter int MAX_BURST      = 8,
  parameter int DEVSEL_TIMEOUT = 4
) (
  input logic          Clock,
  input logic          RST,
  pci_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, END} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  rem_q, rem_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rd_q, rd_d;
  logic        rv_q, rv_d;
  logic        ab_q, ab_d;
  logic        wr_pop;
  logic        cpl;
  logic        tmo;
  logic        wr;
  logic [3:0]  len;
  assign wr  = cmd_q[0];
  assign len = bus.ReqLen == 4'd0 ? 4'd1 : ({28'd0, bus.ReqLen} > MAX_BURST) ? 4'(MAX_BURST) : bus.ReqLen;
  assign cpl = !bus.Trdy && !bus.Devsel;
`ifdef PCI_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(DEVSEL_TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  assign cnt_d = state_q == DATA ? cnt_q + TW'(bus.Devsel) : '0;
  assign tmo   = state_q == DATA && bus.Devsel && cnt_q == TW'(DEVSEL_TIMEOUT - 1);
  always_ff @(posedge Clock or negedge RST)
    if (!RST) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign bus.Abort = state_q == END && ab_q;
`else
  logic unused_cfg;
  assign unused_cfg = DEVSEL_TIMEOUT[0];
  assign tmo        = 1'b0;
  assign bus.Abort  = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wd_d    = wd_q;
    be_d    = be_q;
    rd_d    = rd_q;
    rv_d    = 1'b0;
    ab_d    = ab_q;
    wr_pop  = 1'b0;
    case (state_q)
      IDLE: if (bus.Req) begin
        state_d = ADDR;
        cmd_d   = bus.ReqCmd;
        addr_d  = bus.ReqAddr;
        rem_d   = len;
        ab_d    = 1'b0;
      end
      ADDR: begin
        state_d = DATA;
        wr_pop  = wr;
      end
      DATA: if (tmo) begin
        state_d = END;
        ab_d    = 1'b1;
      end else if (cpl) begin
        rem_d   = rem_q - 4'd1;
        rv_d    = !wr;
        rd_d    = wr ? rd_q : bus.ADIn;
        wr_pop  = wr && rem_q != 4'd1;
        state_d = rem_q == 4'd1 ? END : DATA;
      end
      default: state_d = IDLE;
    endcase
    if (wr_pop) begin
      wd_d = bus.WrData;
      be_d = bus.WrBE;
    end
  end
  always_ff @(posedge Clock or negedge RST)
    if (!RST) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      rd_q    <= '0;
      rv_q    <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      rv_q    <= rv_d;
      ab_q    <= ab_d;
    end
  assign bus.WrPop   = wr_pop;
  assign bus.RdData  = rd_q;
  assign bus.RdValid = rv_q;
  assign bus.Busy    = state_q != IDLE;
  assign bus.Done    = state_q == END && !ab_q;
  assign bus.Frame   = !(state_q == ADDR || (state_q == DATA && rem_q != 4'd1));
  assign bus.Irdy    = state_q != DATA;
  assign bus.CBEOe   = state_q == ADDR || state_q == DATA;
  assign bus.CBE     = state_q == ADDR ? cmd_q : state_q == DATA ? (wr ? be_q : 4'b0000) : 4'hF;
  assign bus.ADOe    = state_q == ADDR || (state_q == DATA && wr);
  assign bus.ADOut   = state_q == ADDR ? addr_q : (state_q == DATA && wr) ? wd_q : 32'd0;
endmodule

// File: tb/tb_pci_master.sv
// tb_pci_master: directed table and sequence checks for pci_master
module tb_pci_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [31:0] CTL_RST = 32'h1F80;
  localparam logic [31:0] W = 32'h33333333;
  pci_master_if bus();
  pci_master #(.MAX_BURST(8), .DEVSEL_TIMEOUT(4)) dut (.Clock(clk), .RST(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic req; logic [3:0] cmd; logic [31:0] addr; logic [3:0] len;
    logic [31:0] wd; logic [3:0] wbe; logic trdy; logic devsel; logic [31:0] adin;
    logic frame; logic irdy; logic [3:0] cbe; logic cbeoe; logic adoe;
    logic wrpop; logic rv; logic busy; logic done; logic [31:0] adout; logic [31:0] rd;
  } vec_t;
  vec_t tv[12];
  logic [31:0] bw_w[3];
  logic [3:0] bw_be[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {19'd0, bus.Frame, bus.Irdy, bus.CBE, bus.CBEOe, bus.ADOe, bus.WrPop, bus.RdValid, bus.Busy, bus.Done, bus.Abort};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.Req = 1'b0; bus.ReqCmd = 4'h0; bus.ReqAddr = 32'h0; bus.ReqLen = 4'h0;
    bus.WrData = 32'h0; bus.WrBE = 4'hF; bus.ADIn = 32'h0; bus.Devsel = 1'b1; bus.Trdy = 1'b1;
  endtask

  task automatic burst_write();
    int wi = 0, ph = 0, np = 0, nd = 0;
    bit popped;
    bus.Req = 1'b1; bus.ReqCmd = 4'h7; bus.ReqAddr = 32'h300; bus.ReqLen = 4'd3;
    bus.WrData = bw_w[0]; bus.WrBE = bw_be[0]; bus.Trdy = 1'b0; bus.Devsel = 1'b0;
    for (int c = 0; c < 20 && nd == 0; c++) begin
      @(negedge clk);
      if (!bus.Irdy && ph < 3) begin
        chk($sformatf("bw ad%0d", ph), bus.ADOut, bw_w[ph]);
        chk($sformatf("bw be%0d", ph), {28'd0, bus.CBE}, {28'd0, bw_be[ph]});
        chk($sformatf("bw frame%0d", ph), {31'd0, bus.Frame}, {31'd0, 1'(ph == 2)});
        ph++;
      end
      popped = bus.WrPop;
      if (popped) np++;
      if (bus.Done) nd++;
      next();
      bus.Req = 1'b0;
      if (popped) begin
        wi++;
        bus.WrData = wi < 3 ? bw_w[wi] : 32'hDEADBEEF;
        bus.WrBE = wi < 3 ? bw_be[wi] : 4'hF;
      end
    end
    chk("bw pops", np, 3);
    chk("bw phases", ph, 3);
    chk("bw done", nd, 1);
    idle_in();
  endtask

  task automatic run_rd(input logic [3:0] cmd, input logic [3:0] len, input int exp_n, input string nm);
    int nd = 0, nrv = 0, nbusy = 0, ndone = 0;
    bit last;
    bus.Req = 1'b1; bus.ReqCmd = cmd; bus.ReqAddr = 32'h2000; bus.ReqLen = len;
    bus.Trdy = 1'b0; bus.Devsel = 1'b0; bus.ADIn = 32'hB0000000;
    for (int c = 0; c < 40 && ndone == 0; c++) begin
      @(negedge clk);
      if (bus.Busy) nbusy++;
      if (bus.RdValid) begin
        chk($sformatf("%s data%0d", nm, nrv), bus.RdData, 32'hB0000000 + nrv);
        nrv++;
      end
      last = !bus.Irdy && bus.Frame;
      if (!bus.Irdy) nd++;
      if (bus.Done) ndone++;
      next();
      if (last) bus.Req = 1'b0;
      bus.ADIn = 32'hB0000000 + nd;
    end
    chk({nm, " phases"}, nd, exp_n);
    chk({nm, " rdvalid"}, nrv, exp_n);
    chk({nm, " busy"}, nbusy, exp_n + 2);
    chk({nm, " done"}, ndone, 1);
    @(negedge clk);
    chk({nm, " idle"}, {31'd0, bus.Busy}, 32'h0);
    next();
    idle_in();
  endtask

  task automatic timeout_seq();
    int nd = 0, nab = 0, ndn = 0, nrv = 0;
    bus.Req = 1'b1; bus.ReqCmd = 4'h6; bus.ReqAddr = 32'h5000; bus.ReqLen = 4'd1;
    bus.Trdy = 1'b0; bus.Devsel = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus.Irdy) nd++;
      if (bus.Abort) begin
        nab++;
        chk("abort released", ctl(), 32'h1F85);
      end
      if (bus.Done) ndn++;
      if (bus.RdValid) nrv++;
      next();
      bus.Req = 1'b0;
`ifndef PCI_MASTER_TIMEOUT_EN
      if (c == 11) bus.Devsel = 1'b0;
`endif
    end
`ifdef PCI_MASTER_TIMEOUT_EN
    chk("to data edges", nd, 4);
    chk("to abort", nab, 1);
    chk("to done", ndn, 0);
    chk("to rdvalid", nrv, 0);
`else
    chk("nto data cycles", nd, 11);
    chk("nto abort", nab, 0);
    chk("nto done", ndn, 1);
    chk("nto rdvalid", nrv, 1);
`endif
    idle_in();
  endtask

  task automatic reset_mid();
    bus.Req = 1'b1; bus.ReqCmd = 4'h7; bus.ReqAddr = 32'h400; bus.ReqLen = 4'd4;
    bus.WrData = 32'h55555555; bus.WrBE = 4'h0; bus.Trdy = 1'b1; bus.Devsel = 1'b0;
    next();
    bus.Req = 1'b0;
    next();
    next();
    @(negedge clk);
    chk("rst pre irdy", {31'd0, bus.Irdy}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst ctl", ctl(), CTL_RST);
    chk("rst ad", bus.ADOut, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst hold%0d", c), ctl(), CTL_RST);
    end
    next();
    rst_n = 1'b1;
    idle_in();
    @(negedge clk);
    chk("rst after", ctl(), CTL_RST);
  endtask

  initial begin
    idle_in();
    bw_w[0] = 32'h11111111; bw_w[1] = 32'h22222222; bw_w[2] = 32'h33333333;
    bw_be[0] = 4'b0000; bw_be[1] = 4'b0101; bw_be[2] = 4'b1010;
    tv[0]  = '{1'b1, 4'h7, 32'd21, 4'd1, W, 4'b1000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tv[1]  = '{1'b0, 4'h7, 32'd21, 4'd1, W, 4'b1000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd21, 32'h0};
    tv[2]  = '{1'b0, 4'h7, 32'd21, 4'd1, W, 4'b1000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, W, 32'h0};
    tv[3]  = '{1'b0, 4'h7, 32'd21, 4'd1, W, 4'b1000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0};
    tv[4]  = '{1'b0, 4'h7, 32'd21, 4'd1, W, 4'b1000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tv[5]  = '{1'b1, 4'h6, 32'h1000, 4'd2, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tv[6]  = '{1'b1, 4'h6, 32'h1000, 4'd2, 32'h0, 4'hF, 1'b0, 1'b0, 32'hDEAD0000, 1'b0, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h0};
    tv[7]  = '{1'b1, 4'h6, 32'h1000, 4'd2, 32'h0, 4'hF, 1'b0, 1'b0, 32'hAAAA0001, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
    tv[8]  = '{1'b0, 4'h6, 32'h1000, 4'd2, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hAAAA0001};
    tv[9]  = '{1'b0, 4'h6, 32'h1000, 4'd2, 32'h0, 4'hF, 1'b0, 1'b0, 32'hAAAA0002, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hAAAA0001};
    tv[10] = '{1'b0, 4'h6, 32'h1000, 4'd2, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hAAAA0002};
    tv[11] = '{1'b0, 4'h6, 32'h1000, 4'd2, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hAAAA0002};
    #3;
    chk("reset ctl", ctl(), CTL_RST);
    chk("reset ad", bus.ADOut, 32'h0);
    chk("reset rd", bus.RdData, 32'h0);
    next();
    next();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.Req = tv[i].req; bus.ReqCmd = tv[i].cmd; bus.ReqAddr = tv[i].addr; bus.ReqLen = tv[i].len;
      bus.WrData = tv[i].wd; bus.WrBE = tv[i].wbe; bus.Trdy = tv[i].trdy; bus.Devsel = tv[i].devsel; bus.ADIn = tv[i].adin;
      @(negedge clk);
      chk($sformatf("row%0d ctl", i), ctl(),
          {19'd0, tv[i].frame, tv[i].irdy, tv[i].cbe, tv[i].cbeoe, tv[i].adoe, tv[i].wrpop, tv[i].rv, tv[i].busy, tv[i].done, 1'b0});
      chk($sformatf("row%0d ad", i), bus.ADOut, tv[i].adout);
      chk($sformatf("row%0d rd", i), bus.RdData, tv[i].rd);
      next();
    end
    idle_in();
    burst_write();
    run_rd(4'h6, 4'd0, 1, "len0");
    run_rd(4'hE, 4'd12, 8, "len12");
    timeout_seq();
    reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pci_master.md
# pci_master

Bus initiator that sits directly upstream of the PCI target. It accepts a single-request transaction command from local logic and drives Frame, Irdy, C/BE and AD through address and data phases. It consumes the target's Devsel and Trdy and moves burst data between a local word stream and the shared AD bus. It supports reads (command 6) and writes (command 7) with bursts of 1..MAX_BURST data phases.

## Interface
Parameters:
- MAX_BURST, 8: maximum data phases per transaction.
- DEVSEL_TIMEOUT, 4: DATA-state edges with Devsel high before master abort (used only with the timeout feature).

Ports:
- Clock  in  1  bus clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- Req  in  1  start request; sampled only in IDLE.
- ReqCmd  in  4  bus command: 6 = memory read, 7 = memory write. Other values: bit0=1 is handled as a write, bit0=0 as a read.
- ReqAddr  in  32  transaction address.
- ReqLen  in  4  number of data phases. 0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST.
- WrData  in  32  next write word.
- WrBE  in  4  byte enables for the next write word (active-low).
- WrPop  out  1  one-cycle pulse: WrData/WrBE loaded into the bus registers this edge.
- RdData  out  32  captured read word.
- RdValid  out  1  one-cycle pulse: RdData is valid.
- Busy  out  1  transaction in progress.
- Done  out  1  one-cycle pulse: normal completion.
- Abort  out  1  one-cycle pulse: master-abort completion.
- Frame  out  1  PCI FRAME#, active-low.
- Irdy  out  1  PCI IRDY#, active-low.
- CBE  out  4  command / byte enables.
- CBEOe  out  1  CBE drive enable.
- ADOut  out  32  AD drive value.
- ADOe  out  1  AD drive enable; the tristate is resolved at the top level.
- ADIn  in  32  resolved AD bus.
- Devsel  in  1  target DEVSEL#, active-low.
- Trdy  in  1  target TRDY#, active-low.

## Operation
- Reset values: Frame=1, Irdy=1, CBE=4'hF, CBEOe=0, ADOut=0, ADOe=0, RdData=0; RdValid, WrPop, Busy, Done and Abort all 0.
- States are IDLE, ADDR, DATA and END.
- IDLE: the bus is released. On Req=1, latch the command, address and clamped length, set Busy=1, and go to ADDR.
- ADDR (one cycle):
  - Drive Frame=0, Irdy=1, ADOut=ReqAddr, ADOe=1, CBE=ReqCmd, CBEOe=1.
  - For writes, load WrData/WrBE on the exit edge and pulse WrPop.
- DATA: Irdy=0.
  - Write: ADOe=1, ADOut=loaded word, CBE=loaded BE.
  - Read: ADOe=0 (turnaround, then the target drives AD), CBE=4'b0000.
- Phase completion: an edge in DATA with Irdy=0, Trdy=0 and Devsel=0.
  - Decrement the remaining count.
  - Read: capture ADIn into RdData and pulse RdValid.
  - Write with phases remaining: load the next WrData/WrBE and pulse WrPop.
- Frame=1 whenever the remaining count is 1 while in DATA, so the last phase is signalled to the target.
- After the last completion, go to END.
- END (one cycle): Frame=1, Irdy=1, ADOe=0, CBEOe=0. Pulse Done (or Abort), then go to IDLE with Busy=0.
- Req while Busy is ignored. Trdy or Devsel activity outside DATA is ignored.
- RST low mid-transaction immediately returns every output to its reset value and releases the bus. No Done or Abort is produced.

## Timing
- Let edge E0 sample Req.
  - Cycle after E0: address phase.
  - Edge E1: enter DATA.
  - Earliest first completion: edge E2.
- Zero-wait write or read of length L: completions at E2..E(L+1), Done high in the cycle after E(L+1), Busy falls at E(L+2). Total L+3 cycles from Req.
- Each target wait state (Trdy=1) adds one cycle. Data, byte enables and Irdy are held unchanged through waits.
- WrPop precedes the use of each word. The source must present the following word before the next completion edge.

## Configuration
- PCI_MASTER_TIMEOUT_EN defined:
  - A counter clears on entering DATA and increments each DATA edge while Devsel=1.
  - When it reaches DEVSEL_TIMEOUT, go to END and pulse Abort instead of Done. No RdValid or WrPop is issued after that point.
- Not defined: the counter logic is absent, Abort is tied to 0, and DATA waits indefinitely for Devsel.

## Test plan
- Reset: RST=0 mid-burst -> Frame=1, Irdy=1, ADOe=0, CBEOe=0, Busy=0 immediately; no Done.
- Single write: Req, ReqCmd=7, ReqAddr=21, ReqLen=1, WrData=32'h33333333, WrBE=4'b1000, target zero-wait -> address phase AD=21/CBE=7, then one data phase with Frame=1, Irdy=0, AD=32'h33333333, CBE=4'b1000; Done pulses 4 cycles after Req.
- Burst write: ReqLen=3, words 32'h11111111/22222222/33333333 -> three WrPop pulses, AD follows the words in order, Frame rises during the third phase.
- Burst read with one wait state: ReqCmd=6, ReqLen=2, target drives AD=32'hAAAA0001 then 32'hAAAA0002 with Trdy=1 for one cycle before the second word -> ADOe=0 during DATA; RdValid pulses twice with those values; total 6 cycles.
- Master abort (PCI_MASTER_TIMEOUT_EN): Devsel held 1 -> Abort pulses after 4 DATA edges, bus released, no RdValid.
- Req while Busy, and ReqLen=0 and ReqLen=12 -> the extra Req is ignored; lengths are executed as 1 and 8 phases respectively.
